// File: rtl/seq_division.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// start/done handshake with ready, plus divide-by-zero flagged in one edge.
module seq_division #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] N,
  input  logic [WIDTH-1:0] D,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             div_by_zero
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CALC = 1'b1;
  localparam int CW = $clog2(WIDTH + 1);

  logic [0:0]       state;
  logic [WIDTH-1:0] dvd;   // dividend shifts out the top, quotient bits shift in the bottom
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   rem_sh, diff;
  logic [WIDTH-1:0] rem_nxt;
  logic             qbit;

  // rem < dvs always holds, so rem_sh < 2*dvs and the borrow bit of diff is the compare result
  always_comb begin
    rem_sh  = {rem, dvd[WIDTH-1]};
    diff    = rem_sh - {1'b0, dvs};
    qbit    = ~diff[WIDTH];
    rem_nxt = qbit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  end

  assign ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      done        <= 1'b0;
      Q           <= '0;
      R           <= '0;
      div_by_zero <= 1'b0;
      dvd         <= '0;
      dvs         <= '0;
      rem         <= '0;
      cnt         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (D == '0) begin
              done        <= 1'b1;
              Q           <= '1;
              R           <= N;
              div_by_zero <= 1'b1;
            end else begin
              dvd   <= N;
              dvs   <= D;
              rem   <= '0;
              cnt   <= CW'(WIDTH);
              state <= CALC;
            end
          end
        end
        CALC: begin
          dvd <= {dvd[WIDTH-2:0], qbit};
          rem <= rem_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            done        <= 1'b1;
            Q           <= {dvd[WIDTH-2:0], qbit};
            R           <= rem_nxt;
            div_by_zero <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_division.sv
// Bench for seq_division: directed vector table, handshake corner sequences,
// and randomised operands against a plain-arithmetic quotient/remainder model.
module tb_seq_division;

  logic        clk = 1'b0;
  logic        rst;
  logic        s16, s8;
  logic [15:0] n16, d16, q16, r16;
  logic [7:0]  n8, d8, q8, r8;
  logic        rdy16, dn16, z16, rdy8, dn8, z8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_division #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .start(s16), .N(n16), .D(d16),
    .ready(rdy16), .done(dn16), .Q(q16), .R(r16), .div_by_zero(z16));

  seq_division #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(s8), .N(n8), .D(d8),
    .ready(rdy8), .done(dn8), .Q(q8), .R(r8), .div_by_zero(z8));

  typedef struct {
    logic [15:0] n, d, q, r;
    logic        z;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic scramble;
    n16 = 16'($urandom); d16 = 16'($urandom);
    n8  = 8'($urandom);  d8  = 8'($urandom);
  endtask

  // Starts a division on the chosen instance and checks latency and results.
  // Returns in the done cycle so the caller may issue a back-to-back start.
  task automatic run(input bit w8, input logic [15:0] n, input logic [15:0] d,
                     input logic [15:0] eq, input logic [15:0] er, input logic ez,
                     input string nm);
    int edges;
    int lat;
    lat = (d == 0) ? 1 : (w8 ? 9 : 17);
    chk({nm, " ready_before"}, w8 ? rdy8 : rdy16, 1);
    if (w8) begin s8 = 1'b1; n8 = n[7:0]; d8 = d[7:0]; end
    else    begin s16 = 1'b1; n16 = n; d16 = d; end
    tick;
    edges = 1;
    s8 = 1'b0; s16 = 1'b0;
    scramble;
    if (d != 0) chk({nm, " ready_busy"}, w8 ? rdy8 : rdy16, 0);
    while (!(w8 ? dn8 : dn16) && edges < 40) begin
      tick;
      edges++;
    end
    chk({nm, " latency"}, edges, lat);
    chk({nm, " Q"}, w8 ? q8 : q16, eq);
    chk({nm, " R"}, w8 ? r8 : r16, er);
    chk({nm, " dbz"}, w8 ? z8 : z16, ez);
    chk({nm, " ready_done"}, w8 ? rdy8 : rdy16, 1);
  endtask

  vec_t tbl[7];

  initial begin
    int edges;
    bit seen;
    logic [15:0] n, d, eq, er;
    logic ez;

    tbl[0] = '{n:16'd100,   d:16'd7,     q:16'd14,    r:16'd2, z:1'b0};
    tbl[1] = '{n:16'd3,     d:16'd10,    q:16'd0,     r:16'd3, z:1'b0};
    tbl[2] = '{n:16'd65535, d:16'd1,     q:16'd65535, r:16'd0, z:1'b0};
    tbl[3] = '{n:16'd65535, d:16'd65535, q:16'd1,     r:16'd0, z:1'b0};
    tbl[4] = '{n:16'd5,     d:16'd0,     q:16'hFFFF,  r:16'd5, z:1'b1};
    tbl[5] = '{n:16'd7,     d:16'd7,     q:16'd1,     r:16'd0, z:1'b0};
    tbl[6] = '{n:16'd40000, d:16'd40001, q:16'd0,     r:16'd40000, z:1'b0};

    rst = 1'b1; s16 = 1'b0; s8 = 1'b0;
    scramble;
    tick; tick;
    rst = 1'b0;
    chk("reset ready16", rdy16, 1);
    chk("reset done16", dn16, 0);
    chk("reset Q16", q16, 0);
    chk("reset R16", r16, 0);
    chk("reset dbz16", z16, 0);
    chk("reset ready8", rdy8, 1);
    chk("reset Q8", q8, 0);

    foreach (tbl[i]) begin
      run(1'b0, tbl[i].n, tbl[i].d, tbl[i].q, tbl[i].r, tbl[i].z, $sformatf("vec%0d", i));
      tick;
      chk($sformatf("vec%0d done_one_cycle", i), dn16, 0);
      chk($sformatf("vec%0d Q_held", i), q16, tbl[i].q);
    end

    // start while busy is ignored; start in the done cycle is accepted
    s16 = 1'b1; n16 = 16'd1000; d16 = 16'd10;
    tick; edges = 1;
    s16 = 1'b0; scramble;
    tick; tick; edges += 2;
    s16 = 1'b1; n16 = 16'd9; d16 = 16'd2;
    tick; edges++;
    s16 = 1'b0; scramble;
    while (!dn16 && edges < 40) begin tick; edges++; end
    chk("busy_ignore latency", edges, 17);
    chk("busy_ignore Q", q16, 100);
    chk("busy_ignore R", r16, 0);
    run(1'b0, 16'd9, 16'd2, 16'd4, 16'd1, 1'b0, "b2b");
    tick;
    chk("b2b done_drop", dn16, 0);

    // reset mid-operation aborts without a done pulse
    s16 = 1'b1; n16 = 16'd1234; d16 = 16'd5;
    tick;
    s16 = 1'b0;
    repeat (4) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort Q", q16, 0);
    chk("abort R", r16, 0);
    chk("abort dbz", z16, 0);
    chk("abort ready", rdy16, 1);
    chk("abort done", dn16, 0);
    seen = 1'b0;
    repeat (20) begin tick; seen |= dn16; end
    chk("abort no_done", seen, 0);
    run(1'b0, 16'd1234, 16'd5, 16'd246, 16'd4, 1'b0, "after_abort");
    tick;

    run(1'b1, 16'd200, 16'd3, 16'd66, 16'd2, 1'b0, "w8_200_3");
    tick;

    for (int k = 0; k < 1000; k++) begin
      n = 16'($urandom);
      case ($urandom_range(0, 9))
        0:       d = 16'd0;
        1, 2:    d = 16'($urandom_range(1, 15));
        3:       d = 16'h8000 | 16'($urandom);
        default: d = 16'($urandom);
      endcase
      if (d == 0) begin eq = 16'hFFFF; er = n; ez = 1'b1; end
      else begin eq = n / d; er = n % d; ez = 1'b0; end
      run(1'b0, n, d, eq, er, ez, $sformatf("rnd16_%0d", k));
      if ($urandom_range(0, 1) == 0) begin
        tick;
        chk($sformatf("rnd16_%0d done_drop", k), dn16, 0);
      end
    end

    for (int k = 0; k < 300; k++) begin
      n = 16'($urandom_range(0, 255));
      d = ($urandom_range(0, 15) == 0) ? 16'd0 : 16'($urandom_range(1, 255));
      if (d == 0) begin eq = 16'h00FF; er = n; ez = 1'b1; end
      else begin eq = n / d; er = n % d; ez = 1'b0; end
      run(1'b1, n, d, eq, er, ez, $sformatf("rnd8_%0d", k));
      if ($urandom_range(0, 1) == 0) begin
        tick;
        chk($sformatf("rnd8_%0d done_drop", k), dn8, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
